// File: rtl/pipe_ctrl_tracker_if.sv
// Control/status bundle between the ID-stage control unit and pipe_ctrl_tracker.
// master = control-unit/datapath side, slave = tracker side.
interface pipe_ctrl_tracker_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             id_wreg;
  logic             id_m2reg;
  logic             id_wmem;
  logic             id_wz;
  logic             id_is_jump;
  logic             id_is_beq;
  logic             id_is_bne;
  logic [REG_W-1:0] id_rd;
  logic             stall_en;
  logic             alu_z;

  logic [REG_W-1:0] exe_rd;
  logic [REG_W-1:0] mem_rd;
  logic [REG_W-1:0] wb_rd;
  logic             exe_wreg;
  logic             mem_wreg;
  logic             wb_wreg;
  logic             exe_m2reg;
  logic             mem_m2reg;
  logic             wb_m2reg;
  logic             exe_wmem;
  logic             mem_wmem;
  logic             exe_is_jump;
  logic             exe_is_beq;
  logic             exe_is_bne;
  logic             mem_branch;
  logic             wb_branch;
  logic             rsrtequ;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_wreg, id_m2reg, id_wmem, id_wz, id_is_jump, id_is_beq, id_is_bne, id_rd,
    output stall_en, alu_z,
    input  exe_rd, mem_rd, wb_rd, exe_wreg, mem_wreg, wb_wreg,
    input  exe_m2reg, mem_m2reg, wb_m2reg, exe_wmem, mem_wmem,
    input  exe_is_jump, exe_is_beq, exe_is_bne, mem_branch, wb_branch,
    input  rsrtequ, bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_wreg, id_m2reg, id_wmem, id_wz, id_is_jump, id_is_beq, id_is_bne, id_rd,
    input  stall_en, alu_z,
    output exe_rd, mem_rd, wb_rd, exe_wreg, mem_wreg, wb_wreg,
    output exe_m2reg, mem_m2reg, wb_m2reg, exe_wmem, mem_wmem,
    output exe_is_jump, exe_is_beq, exe_is_bne, mem_branch, wb_branch,
    output rsrtequ, bubble, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_tracker.sv
// EXE/MEM/WB control shift structure with bubble insertion and branch resolution.
// Optional stall/flush performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_tracker #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_ctrl_tracker_if.slave   bus
);

  logic             exe_wreg_q, exe_m2reg_q, exe_wmem_q, exe_wz_q;
  logic             exe_is_jump_q, exe_is_beq_q, exe_is_bne_q;
  logic [REG_W-1:0] exe_rd_q;
  logic             exe_wreg_d, exe_m2reg_d, exe_wmem_d, exe_wz_d;
  logic             exe_is_jump_d, exe_is_beq_d, exe_is_bne_d;
  logic [REG_W-1:0] exe_rd_d;

  logic             mem_wreg_q, mem_m2reg_q, mem_wmem_q, mem_branch_q;
  logic [REG_W-1:0] mem_rd_q;
  logic             wb_wreg_q, wb_m2reg_q, wb_branch_q;
  logic [REG_W-1:0] wb_rd_q;
  logic             rsrtequ_q;

  logic             bubble;
  logic             branch_taken;

  // Only registered state and stall_en feed the bubble; alu_z never does.
  assign bubble       = bus.stall_en | exe_is_jump_q | mem_branch_q | wb_branch_q;
  assign branch_taken = (exe_is_beq_q & bus.alu_z) | (exe_is_bne_q & ~bus.alu_z);

  always_comb begin
    exe_wreg_d    = 1'b0;
    exe_m2reg_d   = 1'b0;
    exe_wmem_d    = 1'b0;
    exe_wz_d      = 1'b0;
    exe_is_jump_d = 1'b0;
    exe_is_beq_d  = 1'b0;
    exe_is_bne_d  = 1'b0;
    exe_rd_d      = '0;
    if (!bubble) begin
      exe_wreg_d    = bus.id_wreg;
      exe_m2reg_d   = bus.id_m2reg;
      exe_wmem_d    = bus.id_wmem;
      exe_wz_d      = bus.id_wz;
      exe_is_jump_d = bus.id_is_jump;
      exe_is_beq_d  = bus.id_is_beq;
      exe_is_bne_d  = bus.id_is_bne;
      exe_rd_d      = bus.id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_wreg_q    <= 1'b0;
      exe_m2reg_q   <= 1'b0;
      exe_wmem_q    <= 1'b0;
      exe_wz_q      <= 1'b0;
      exe_is_jump_q <= 1'b0;
      exe_is_beq_q  <= 1'b0;
      exe_is_bne_q  <= 1'b0;
      exe_rd_q      <= '0;
      mem_wreg_q    <= 1'b0;
      mem_m2reg_q   <= 1'b0;
      mem_wmem_q    <= 1'b0;
      mem_branch_q  <= 1'b0;
      mem_rd_q      <= '0;
      wb_wreg_q     <= 1'b0;
      wb_m2reg_q    <= 1'b0;
      wb_branch_q   <= 1'b0;
      wb_rd_q       <= '0;
      rsrtequ_q     <= 1'b0;
    end else begin
      exe_wreg_q    <= exe_wreg_d;
      exe_m2reg_q   <= exe_m2reg_d;
      exe_wmem_q    <= exe_wmem_d;
      exe_wz_q      <= exe_wz_d;
      exe_is_jump_q <= exe_is_jump_d;
      exe_is_beq_q  <= exe_is_beq_d;
      exe_is_bne_q  <= exe_is_bne_d;
      exe_rd_q      <= exe_rd_d;
      mem_wreg_q    <= exe_wreg_q;
      mem_m2reg_q   <= exe_m2reg_q;
      mem_wmem_q    <= exe_wmem_q;
      mem_branch_q  <= branch_taken;
      mem_rd_q      <= exe_rd_q;
      wb_wreg_q     <= mem_wreg_q;
      wb_m2reg_q    <= mem_m2reg_q;
      wb_branch_q   <= mem_branch_q;
      wb_rd_q       <= mem_rd_q;
      if (exe_wz_q) begin
        rsrtequ_q <= bus.alu_z;
      end
    end
  end

  assign bus.exe_wreg    = exe_wreg_q;
  assign bus.exe_m2reg   = exe_m2reg_q;
  assign bus.exe_wmem    = exe_wmem_q;
  assign bus.exe_is_jump = exe_is_jump_q;
  assign bus.exe_is_beq  = exe_is_beq_q;
  assign bus.exe_is_bne  = exe_is_bne_q;
  assign bus.exe_rd      = exe_rd_q;
  assign bus.mem_wreg    = mem_wreg_q;
  assign bus.mem_m2reg   = mem_m2reg_q;
  assign bus.mem_wmem    = mem_wmem_q;
  assign bus.mem_branch  = mem_branch_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.wb_wreg     = wb_wreg_q;
  assign bus.wb_m2reg    = wb_m2reg_q;
  assign bus.wb_branch   = wb_branch_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.rsrtequ     = rsrtequ_q;
  assign bus.bubble      = bubble;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // A cycle that both stalls and flushes counts as a stall only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.stall_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (bubble && !bus.stall_en && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
